// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle for rr_mux_arbiter.
// The lock vector exists only when RRMUX_LOCK_EN is defined.
interface rr_mux_arbiter_if #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int W = 1
);
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic           ready;
`ifdef RRMUX_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [M-1:0]   sel;
    logic [W-1:0]   y;
    logic           valid;

`ifdef RRMUX_LOCK_EN
    modport master (output req, din, ready, lock, input gnt, sel, y, valid);
    modport slave  (input req, din, ready, lock, output gnt, sel, y, valid);
`else
    modport master (output req, din, ready, input gnt, sel, y, valid);
    modport slave  (input req, din, ready, output gnt, sel, y, valid);
`endif
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 mux arbiter with registered output and valid/ready handshake.
// Optional bus lock enabled by defining RRMUX_LOCK_EN.
//
// state  | meaning
// IDLE   | y empty, valid=0
// BUSY   | y holds a round-robin winner, valid=1
// LOCKED | y holds the lock owner re-granted without advancing ptr (RRMUX_LOCK_EN)
module rr_mux_arbiter #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
);

`ifdef RRMUX_LOCK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, LOCKED = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

    state_t         state;
    logic [M-1:0]   ptr;
    logic [M-1:0]   sel_q;
    logic [W-1:0]   y_q;
    logic [N-1:0]   gnt_q;

    logic           load_ok;
    logic           found;
    logic [M-1:0]   winner;
    logic [M-1:0]   pick;
    logic [M-1:0]   ptr_nxt;

    assign load_ok = (state == IDLE) || bus.ready;

    // Scan from ptr upward, wrapping at N, first requester wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = M'(idx);
            end
        end
    end

`ifdef RRMUX_LOCK_EN
    logic lock_hit;
    assign lock_hit = (state != IDLE) && bus.req[sel_q] && bus.lock[sel_q];
    assign pick     = lock_hit ? sel_q : winner;
`else
    assign pick     = winner;
`endif

    assign ptr_nxt = (pick == M'(N-1)) ? '0 : pick + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            y_q   <= '0;
            gnt_q <= '0;
        end else begin
            gnt_q <= '0;
            if (load_ok) begin
                if (found) begin
                    sel_q <= pick;
                    y_q   <= bus.din[int'(pick)*W +: W];
                    gnt_q <= {{(N-1){1'b0}}, 1'b1} << pick;
`ifdef RRMUX_LOCK_EN
                    if (lock_hit) begin
                        state <= LOCKED;
                    end else begin
                        state <= BUSY;
                        ptr   <= ptr_nxt;
                    end
`else
                    state <= BUSY;
                    ptr   <= ptr_nxt;
`endif
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.y     = y_q;
    assign bus.valid = (state != IDLE);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N=4, M=2, W=8): directed scenarios
// against fixed expectations, then random traffic against a behavioural model.
module tb_rr_mux_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    rr_mux_arbiter_if #(.N(4), .M(2), .W(8)) bus ();

    rr_mux_arbiter #(.N(4), .M(2), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] DIN_FIXED = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic [7:0] dval [4];

    // Reference model state: what the consumer should see after each edge.
    int         m_ptr;
    bit         m_valid;
    int         m_sel;
    logic [7:0] m_y;
    logic [3:0] m_gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_eval();
        int w;
        bit keep;
        w    = -1;
        keep = 1'b0;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 1'b0; m_sel = 0; m_y = 8'h00; m_gnt = 4'b0000;
            return;
        end
        m_gnt = 4'b0000;
        if (m_valid && !bus.ready) return;
        if (bus.req == 4'b0000) begin
            m_valid = 1'b0;
            return;
        end
`ifdef RRMUX_LOCK_EN
        if (m_valid && bus.req[m_sel] && bus.lock[m_sel]) begin
            w    = m_sel;
            keep = 1'b1;
        end
`endif
        for (int k = 0; k < 4; k++)
            if (w < 0 && bus.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        m_sel   = w;
        m_y     = bus.din[w*8 +: 8];
        m_valid = 1'b1;
        m_gnt   = 4'(1 << w);
        if (!keep) m_ptr = (w + 1) % 4;
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        bus.din   = DIN_FIXED;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
                n_err++;
                $display("FAIL reset[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want all zero",
                         i, bus.gnt, bus.sel, bus.y, bus.valid);
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] es;
        rst_n     = 1'b1;
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            es = 2'(i % 4);
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'(1 << es), es, dval[es], 1'b1}) begin
                n_err++;
                $display("FAIL rotation[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want gnt=%b sel=%0d y=%h valid=1",
                         i, bus.gnt, bus.sel, bus.y, bus.valid, 4'(1 << es), es, dval[es]);
            end
        end
    endtask

    task automatic test_stall();
        bus.ready = 1'b1;
        step();
        n_cmp++;
        if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0010, 2'd1, 8'hB1, 1'b1}) begin
            n_err++;
            $display("FAIL stall_load: got gnt=%b sel=%0d y=%h valid=%b, want gnt=0010 sel=1 y=b1 valid=1",
                     bus.gnt, bus.sel, bus.y, bus.valid);
        end
        bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0000, 2'd1, 8'hB1, 1'b1}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want gnt=0000 sel=1 y=b1 valid=1",
                         i, bus.gnt, bus.sel, bus.y, bus.valid);
            end
        end
        bus.ready = 1'b1;
        step();
        n_cmp++;
        if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0100, 2'd2, 8'hC2, 1'b1}) begin
            n_err++;
            $display("FAIL stall_release: got gnt=%b sel=%0d y=%h valid=%b, want gnt=0100 sel=2 y=c2 valid=1",
                     bus.gnt, bus.sel, bus.y, bus.valid);
        end
    endtask

    task automatic test_sparse_wrap();
        logic [1:0] es [3];
        es[0] = 2'd3; es[1] = 2'd0; es[2] = 2'd3;
        bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req = (i == 0) ? 4'b1111 : 4'b1001;
            step();
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'(1 << es[i]), es[i], dval[es[i]], 1'b1}) begin
                n_err++;
                $display("FAIL sparse_wrap[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want sel=%0d y=%h valid=1",
                         i, bus.gnt, bus.sel, bus.y, bus.valid, es[i], dval[es[i]]);
            end
        end
    endtask

    task automatic test_idle();
        bus.req   = 4'b0000;
        bus.ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0000, 2'd3, 8'hD3, 1'b0}) begin
                n_err++;
                $display("FAIL idle[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want gnt=0000 sel=3 y=d3 valid=0",
                         i, bus.gnt, bus.sel, bus.y, bus.valid);
            end
        end
        bus.req = 4'b0001;
        step();
        n_cmp++;
        if ({bus.sel, bus.valid} !== {2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL idle_reload: got sel=%0d valid=%b, want sel=0 valid=1", bus.sel, bus.valid);
        end
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        step();
        n_cmp++;
        if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL midreset: got gnt=%b sel=%0d y=%h valid=%b, want all zero",
                     bus.gnt, bus.sel, bus.y, bus.valid);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'b0001, 2'd0, 8'hA0, 1'b1}) begin
            n_err++;
            $display("FAIL ptr_after_reset: got gnt=%b sel=%0d y=%h valid=%b, want gnt=0001 sel=0 y=a0 valid=1",
                     bus.gnt, bus.sel, bus.y, bus.valid);
        end
    endtask

`ifdef RRMUX_LOCK_EN
    task automatic test_lock();
        logic [1:0] es [6];
        es[0] = 2'd0; es[1] = 2'd1; es[2] = 2'd1; es[3] = 2'd1; es[4] = 2'd1; es[5] = 2'd2;
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        bus.lock  = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.lock = 4'b0000;
            step();
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {4'(1 << es[i]), es[i], dval[es[i]], 1'b1}) begin
                n_err++;
                $display("FAIL lock[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want sel=%0d y=%h valid=1",
                         i, bus.gnt, bus.sel, bus.y, bus.valid, es[i], dval[es[i]]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] prev_req;
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 40) != 0);
            bus.req   = 4'($urandom_range(0, 15));
            bus.ready = ($urandom_range(0, 3) != 0);
            bus.din   = $urandom;
`ifdef RRMUX_LOCK_EN
            bus.lock  = 4'($urandom_range(0, 15));
`endif
            prev_req = bus.req;
            step();
            n_cmp++;
            if ({bus.gnt, bus.sel, bus.y, bus.valid} !== {m_gnt, 2'(m_sel), m_y, m_valid}) begin
                n_err++;
                $display("FAIL random[%0d]: got gnt=%b sel=%0d y=%h valid=%b, want gnt=%b sel=%0d y=%h valid=%b",
                         i, bus.gnt, bus.sel, bus.y, bus.valid, m_gnt, m_sel, m_y, m_valid);
            end
            n_cmp++;
            if ((bus.gnt & ~prev_req) !== 4'b0000) begin
                n_err++;
                $display("FAIL gnt_without_req[%0d]: got gnt=%b, req was %b", i, bus.gnt, prev_req);
            end
        end
        bus.din = DIN_FIXED;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        dval[0] = 8'hA0; dval[1] = 8'hB1; dval[2] = 8'hC2; dval[3] = 8'hD3;
        m_ptr = 0; m_valid = 1'b0; m_sel = 0; m_y = 8'h00; m_gnt = 4'b0000;
        rst_n     = 1'b0;
        bus.req   = 4'b0000;
        bus.ready = 1'b1;
        bus.din   = DIN_FIXED;
`ifdef RRMUX_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        test_reset();
        test_rotation();
        test_stall();
        test_sparse_wrap();
        test_idle();
`ifdef RRMUX_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
